// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA timing generator with border, colour-bar, checker and gradient patterns
// Sync and colour outputs are registered on the pixel strobe, one pixel behind x/y.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int COLOR_W    = 4,
    parameter int CLK_DIV    = 2,
    parameter int BORDER_W   = 3,
    parameter int SQ_LOG2    = 5,
    parameter int GRAD_SHIFT = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic               pix_en,
    output logic               frame_start,
    output logic               hSync_n,
    output logic               vSync_n,
    output logic [COLOR_W-1:0] vgaR,
    output logic [COLOR_W-1:0] vgaG,
    output logic [COLOR_W-1:0] vgaB
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         mode_q;
    logic [1:0]         mode_eff;
    logic               active;
    logic               hs_n;
    logic               vs_n;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] r_n;
    logic [COLOR_W-1:0] g_n;
    logic [COLOR_W-1:0] b_n;

    assign frame_start = pix_en && (x == 10'd0) && (y == 10'd0);
    // The origin pixel already belongs to the new frame, so it must see the newly latched mode.
    assign mode_eff    = frame_start ? mode : mode_q;
    assign active      = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    assign hs_n        = !((x >= 10'(H_ACTIVE + H_FP)) && (x < 10'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_n        = !((y >= 10'(V_ACTIVE + V_FP)) && (y < 10'(V_ACTIVE + V_FP + V_SYNC)));

    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 10'(i * BAR_W)) bar = 3'(i);
        end
        if (active) begin
            case (mode_eff)
                2'd0: begin
                    if ((x < 10'(BORDER_W)) || (x >= 10'(H_ACTIVE - BORDER_W))) r_n = FULL;
                    if ((y < 10'(BORDER_W)) || (y >= 10'(V_ACTIVE - BORDER_W))) b_n = FULL;
                end
                2'd1: begin
                    r_n = bar[2] ? FULL : '0;
                    g_n = bar[1] ? FULL : '0;
                    b_n = bar[0] ? FULL : '0;
                end
                2'd2: begin
                    if (x[SQ_LOG2] ^ y[SQ_LOG2]) begin
                        r_n = FULL;
                        g_n = FULL;
                        b_n = FULL;
                    end
                end
                default: begin
                    r_n = COLOR_W'(x >> GRAD_SHIFT);
                    g_n = COLOR_W'(x >> GRAD_SHIFT);
                    b_n = COLOR_W'(x >> GRAD_SHIFT);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
            x       <= '0;
            y       <= '0;
            mode_q  <= '0;
            hSync_n <= 1'b1;
            vSync_n <= 1'b1;
            vgaR    <= '0;
            vgaG    <= '0;
            vgaB    <= '0;
        end else begin
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                pix_en  <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                pix_en  <= 1'b0;
            end
            if (pix_en) begin
                if (x == 10'(H_TOTAL - 1)) begin
                    x <= '0;
                    y <= (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
                hSync_n <= hs_n;
                vSync_n <= vs_n;
                vgaR    <= r_n;
                vgaG    <= g_n;
                vgaB    <= b_n;
            end
            if (frame_start) mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed-vector bench for vga_pattern_gen on a reduced raster
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 32, H_FP = 4, H_SYNC = 4, H_BP = 4;
    localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int CLK_DIV = 2;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int LIMIT   = 3 * FRAME;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [9:0] x, y;
    logic       pix_en, frame_start, hSync_n, vSync_n;
    logic [3:0] vgaR, vgaG, vgaB;

    vga_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COLOR_W(4), .CLK_DIV(CLK_DIV), .BORDER_W(3), .SQ_LOG2(3), .GRAD_SHIFT(1)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .x(x), .y(y),
        .pix_en(pix_en), .frame_start(frame_start),
        .hSync_n(hSync_n), .vSync_n(vSync_n),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [1:0] mode;
        int         px;
        int         py;
        logic [3:0] r, g, b;
        logic       hs, vs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] m, input int px, input int py,
                                input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                                input logic hs, input logic vs);
        vec_t v;
        v.mode = m; v.px = px; v.py = py;
        v.r = r; v.g = g; v.b = b; v.hs = hs; v.vs = vs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return hSync_n;
            1:       return vSync_n;
            2:       return frame_start;
            default: return pix_en;
        endcase
    endfunction

    task automatic wait_level(input int which, input logic lvl, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < LIMIT; n++) begin
            if (sig(which) === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_pix(input int px, input int py, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < LIMIT; n++) begin
            if (pix_en === 1'b1 && x == 10'(px) && y == 10'(py)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_pixel(input string name, input int px, input int py,
                               input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        bit ok;
        wait_pix(px, py, ok);
        if (!ok) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            check(name, {vgaR, vgaG, vgaB}, {r, g, b});
        end
    endtask

    task automatic wait_frame(input string name);
        bit ok;
        @(negedge clk);
        wait_level(2, 1'b0, ok);
        wait_level(2, 1'b1, ok);
        if (!ok) check({name, "_frame_timeout"}, 0, 1);
    endtask

    initial begin
        bit ok;
        int t0, t1, t2;
        logic [1:0] cur_mode;
        localparam logic [3:0] F = 4'hF;

        // Mode 0: border
        vecs.push_back(mk(0,  0,  0, F, 0, F, 1, 1));
        vecs.push_back(mk(0, 16,  0, 0, 0, F, 1, 1));
        vecs.push_back(mk(0,  2, 10, F, 0, 0, 1, 1));
        vecs.push_back(mk(0,  3, 10, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 16, 12, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 28, 12, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 29, 12, F, 0, 0, 1, 1));
        vecs.push_back(mk(0, 31, 12, F, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32, 12, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 35, 13, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 36, 13, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 39, 13, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 40, 13, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 16, 20, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 16, 21, 0, 0, F, 1, 1));
        vecs.push_back(mk(0, 31, 23, F, 0, F, 1, 1));
        vecs.push_back(mk(0,  0, 25, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0,  0, 26, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0,  0, 27, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0,  0, 28, 0, 0, 0, 1, 1));
        // Mode 1: colour bars, 4 pixels wide
        vecs.push_back(mk(1,  0,  5, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1,  4,  5, 0, 0, F, 1, 1));
        vecs.push_back(mk(1, 11,  5, 0, F, 0, 1, 1));
        vecs.push_back(mk(1, 16,  5, F, 0, 0, 1, 1));
        vecs.push_back(mk(1, 23,  5, F, 0, F, 1, 1));
        vecs.push_back(mk(1, 31,  5, F, F, F, 1, 1));
        vecs.push_back(mk(1, 32,  5, 0, 0, 0, 1, 1));
        // Mode 2: 8x8 checker
        vecs.push_back(mk(2,  0,  0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(2,  8,  0, F, F, F, 1, 1));
        vecs.push_back(mk(2,  7,  7, 0, 0, 0, 1, 1));
        vecs.push_back(mk(2,  0,  8, F, F, F, 1, 1));
        vecs.push_back(mk(2,  8,  8, 0, 0, 0, 1, 1));
        vecs.push_back(mk(2, 16,  9, F, F, F, 1, 1));
        // Mode 3: gradient from x[1 +: 4]
        vecs.push_back(mk(3,  1,  3, 0, 0, 0, 1, 1));
        vecs.push_back(mk(3,  2,  3, 1, 1, 1, 1, 1));
        vecs.push_back(mk(3,  3,  3, 1, 1, 1, 1, 1));
        vecs.push_back(mk(3,  6,  3, 3, 3, 3, 1, 1));
        vecs.push_back(mk(3, 30,  3, F, F, F, 1, 1));
        vecs.push_back(mk(3, 31,  3, F, F, F, 1, 1));
        vecs.push_back(mk(3, 32,  3, 0, 0, 0, 1, 1));

        reset = 1'b1;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_xy", {x, y}, 20'd0);
        check("rst_strobes", {pix_en, frame_start}, 2'b00);
        check("rst_sync", {hSync_n, vSync_n}, 2'b11);
        check("rst_rgb", {vgaR, vgaG, vgaB}, 12'd0);

        reset = 1'b0;
        t0 = cyc;
        wait_level(3, 1'b1, ok);
        check("first_pix_en_delay", cyc - t0, CLK_DIV);
        check("first_pix_xy", {x, y}, 20'd0);
        check("first_frame_start", frame_start, 1'b1);

        wait_level(0, 1'b1, ok); wait_level(0, 1'b0, ok); t0 = cyc;
        wait_level(0, 1'b1, ok); t1 = cyc;
        wait_level(0, 1'b0, ok); t2 = cyc;
        check("hsync_ok", ok, 1'b1);
        check("hsync_low", t1 - t0, H_SYNC * CLK_DIV);
        check("hsync_period", t2 - t0, H_TOTAL * CLK_DIV);

        wait_level(1, 1'b1, ok); wait_level(1, 1'b0, ok); t0 = cyc;
        wait_level(1, 1'b1, ok); t1 = cyc;
        wait_level(1, 1'b0, ok); t2 = cyc;
        check("vsync_ok", ok, 1'b1);
        check("vsync_low", t1 - t0, V_SYNC * H_TOTAL * CLK_DIV);
        check("vsync_period", t2 - t0, FRAME);

        wait_level(2, 1'b0, ok); wait_level(2, 1'b1, ok); t0 = cyc;
        @(negedge clk);
        check("frame_start_width", frame_start, 1'b0);
        wait_level(2, 1'b1, ok); t2 = cyc;
        check("frame_start_period", t2 - t0, FRAME);

        cur_mode = 2'd0;
        foreach (vecs[i]) begin
            if (vecs[i].mode != cur_mode) begin
                mode = vecs[i].mode;
                cur_mode = vecs[i].mode;
                wait_frame($sformatf("vec%0d", i));
            end
            wait_pix(vecs[i].px, vecs[i].py, ok);
            if (!ok) begin
                check($sformatf("vec%0d_timeout", i), 0, 1);
            end else begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("vec%0d_m%0d_x%0d_y%0d", i, vecs[i].mode, vecs[i].px, vecs[i].py),
                      {vgaR, vgaG, vgaB, hSync_n, vSync_n},
                      {vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].hs, vecs[i].vs});
            end
        end

        // Mode change mid-frame must not disturb the current frame.
        mode = 2'd1;
        wait_frame("mchg");
        wait_pix(0, 10, ok);
        mode = 2'd2;
        check_pixel("mchg_same_frame_bars", 8, 15, 4'h0, 4'hF, 4'h0);
        check_pixel("mchg_next_frame_checker", 8, 0, 4'hF, 4'hF, 4'hF);

        // Reset mid-frame returns everything to origin.
        wait_pix(20, 12, ok);
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_white", {vgaR, vgaG, vgaB}, 12'hFFF);
        reset = 1'b1;
        #1;
        check("midrst_xy", {x, y}, 20'd0);
        check("midrst_strobes", {pix_en, frame_start}, 2'b00);
        check("midrst_sync_rgb", {hSync_n, vSync_n, vgaR, vgaG, vgaB}, {2'b11, 12'd0});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        wait_level(2, 1'b1, ok);
        check("midrst_first_frame_start", cyc - t0, CLK_DIV);
        @(negedge clk);
        wait_level(2, 1'b1, ok);
        check("midrst_next_frame_start", cyc - t0, FRAME + CLK_DIV);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
